// File: rtl/lm07_spi_reader.sv
// 3-wire SPI master for the LM07/LM70 temperature sensor: clocks in one 16-bit
// frame MSB-first and publishes the raw word plus whole-degree magnitude and sign.
module lm07_spi_reader #(
    parameter int DIV = 2,
    parameter int GAP = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        sio,
    output logic        cs,
    output logic        sck,
    output logic [15:0] data,
    output logic [7:0]  temp_c,
    output logic        neg,
    output logic        valid,
    output logic        busy
);

    localparam int CMAX = (DIV > GAP) ? DIV : GAP;
    localparam int CW   = $clog2(CMAX + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SCK_HI,
        ST_SCK_LO,
        ST_GAP
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [4:0]    bit_cnt_q, bit_cnt_d;
    logic [15:0]   shift_q, shift_d;
    logic [15:0]   data_q, data_d;
    logic [7:0]    temp_q, temp_d;
    logic          neg_q, neg_d;
    logic          valid_q, valid_d;
    logic          cs_q, cs_d;
    logic          sck_q, sck_d;

    logic          phase_done;
    logic          gap_done;
    logic [8:0]    whole;
    logic [8:0]    whole_neg;

    // Whole degrees sit in bits 15:7 as a 9-bit two's-complement value.
    assign whole     = shift_q[15:7];
    assign whole_neg = -whole;

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        data_d     = data_q;
        temp_d     = temp_q;
        neg_d      = neg_q;
        valid_d    = 1'b0;
        phase_done = (cnt_q == CW'(DIV - 1));
        gap_done   = (cnt_q == CW'(GAP - 1));

        case (state_q)
            ST_IDLE: begin
                cnt_d     = '0;
                bit_cnt_d = '0;
                if (en) begin
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (phase_done) begin
                    state_d   = ST_SCK_HI;
                    cnt_d     = '0;
                    shift_d   = {shift_q[14:0], sio};
                    bit_cnt_d = bit_cnt_q + 5'd1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_SCK_HI: begin
                if (phase_done) begin
                    state_d = ST_SCK_LO;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_SCK_LO: begin
                if (phase_done) begin
                    cnt_d = '0;
                    if (bit_cnt_q == 5'd16) begin
                        state_d   = ST_GAP;
                        bit_cnt_d = '0;
                        data_d    = shift_q;
                        neg_d     = shift_q[15];
                        temp_d    = shift_q[15] ? whole_neg[7:0] : whole[7:0];
                        valid_d   = 1'b1;
                    end else begin
                        state_d   = ST_SCK_HI;
                        shift_d   = {shift_q[14:0], sio};
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_GAP: begin
                if (gap_done) begin
                    cnt_d   = '0;
                    state_d = en ? ST_SETUP : ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        // Pin levels are decoded from the next state so they leave the flops aligned with it.
        cs_d  = !(state_d inside {ST_SETUP, ST_SCK_HI, ST_SCK_LO});
        sck_d = (state_d == ST_SCK_HI);
    end

    // NOTE: the shift register and counters are reset along with the outputs, so an
    // aborted frame can never leak into data after reset releases.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            temp_q    <= '0;
            neg_q     <= 1'b0;
            valid_q   <= 1'b0;
            cs_q      <= 1'b1;
            sck_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking updates keep every flop sampling the pre-edge values.
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            temp_q    <= temp_d;
            neg_q     <= neg_d;
            valid_q   <= valid_d;
            cs_q      <= cs_d;
            sck_q     <= sck_d;
        end
    end

    assign cs     = cs_q;
    assign sck    = sck_q;
    assign data   = data_q;
    assign temp_c = temp_q;
    assign neg    = neg_q;
    assign valid  = valid_q;
    assign busy   = ~cs_q;

endmodule
